// File: rtl/wts_channel_mixer_n.sv
// Time-multiplexed stereo mixer: scans CH_NUM channels one per clock after each
// sample tick, accumulates volume-scaled samples per side, then shifts and saturates.
module wts_channel_mixer_n #(
  parameter int CH_NUM = 12,
  parameter int WAVE_W = 8,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic [CH_NUM*WAVE_W-1:0] ch_sample,
  input  logic [CH_NUM*VOL_W-1:0]  ch_volume,
  input  logic [CH_NUM*2-1:0]      ch_enable,
  input  logic                     mute,
  input  logic                     overrun_clr,
  output logic [OUT_W-1:0]         left_out,
  output logic [OUT_W-1:0]         right_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int P     = WAVE_W + VOL_W;
  localparam int ACC_W = P + $clog2(CH_NUM);
  localparam int IDX_W = $clog2(CH_NUM);
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          ch_idx;
  logic signed [ACC_W-1:0]   acc_l, acc_r;
  logic signed [WAVE_W-1:0]  cur_sample;
  logic [VOL_W-1:0]          cur_vol;
  logic [1:0]                cur_en;
  logic signed [P-1:0]       product;
  logic signed [ACC_W-1:0]   product_ext;
  logic                      busy_i;
  logic                      tick_accept;
  logic                      last_ch;

  function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] r;
    r = EXT_W'(a >>> SHIFT);
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return OUT_W'(r);
  endfunction

  // The out_valid cycle still counts as busy, so a tick landing on it is an overrun.
  assign busy_i      = (state != IDLE) || out_valid;
  assign busy        = busy_i;
  assign tick_accept = sample_tick && !busy_i;
  assign last_ch     = (ch_idx == IDX_W'(CH_NUM - 1));

  always_comb begin
    cur_sample  = $signed(ch_sample[ch_idx*WAVE_W +: WAVE_W]);
    cur_vol     = ch_volume[ch_idx*VOL_W +: VOL_W];
    cur_en      = ch_enable[ch_idx*2 +: 2];
    product     = P'(cur_sample) * P'($signed({1'b0, cur_vol}));
    product_ext = ACC_W'(product);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick_accept) state_nxt = SCAN;
      SCAN:    if (last_ch)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ch_idx    <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_accept) begin
            acc_l  <= '0;
            acc_r  <= '0;
            ch_idx <= '0;
          end
        end
        SCAN: begin
          if (cur_en[0]) acc_l <= acc_l + product_ext;
          if (cur_en[1]) acc_r <= acc_r + product_ext;
          ch_idx <= last_ch ? '0 : ch_idx + 1'b1;
        end
        DONE: begin
          left_out  <= mute ? '0 : saturate(acc_l);
          right_out <= mute ? '0 : saturate(acc_r);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
      if (sample_tick && busy_i) overrun <= 1'b1;
      else if (overrun_clr)      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wts_channel_mixer_n.sv
// Directed bench for wts_channel_mixer_n: a vector table of single frames plus
// hand-written overrun, reset-abort and mute sequences.
module tb_wts_channel_mixer_n;

  localparam int CH = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_tick;
  logic [CH*8-1:0]  ch_sample;
  logic [CH*4-1:0]  ch_volume;
  logic [CH*2-1:0]  ch_enable;
  logic             mute;
  logic             overrun_clr;
  logic [11:0]      left_out;
  logic [11:0]      right_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  int errors = 0;
  int checks = 0;
  int ov_cnt = 0;

  wts_channel_mixer_n #(.CH_NUM(CH), .WAVE_W(8), .VOL_W(4), .OUT_W(12), .SHIFT(2)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .ch_sample(ch_sample), .ch_volume(ch_volume), .ch_enable(ch_enable),
    .mute(mute), .overrun_clr(overrun_clr),
    .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) ov_cnt++;

  typedef struct {
    string           name;
    logic [CH*8-1:0] s;
    logic [CH*4-1:0] v;
    logic [CH*2-1:0] e;
    int              exp_l;
    int              exp_r;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_ch(input int i, input int ch, input int s, input int v, input int e);
    vecs[i].s[ch*8 +: 8] = 8'(s);
    vecs[i].v[ch*4 +: 4] = 4'(v);
    vecs[i].e[ch*2 +: 2] = 2'(e);
  endtask

  task automatic init_vec(input int i, input string nm, input int l, input int r);
    vecs[i].name  = nm;
    vecs[i].s     = '0;
    vecs[i].v     = '0;
    vecs[i].e     = '0;
    vecs[i].exp_l = l;
    vecs[i].exp_r = r;
  endtask

  task automatic apply(input int i);
    ch_sample = vecs[i].s;
    ch_volume = vecs[i].v;
    ch_enable = vecs[i].e;
  endtask

  // Called #1 after a rising edge; returns edges from the tick edge to out_valid.
  task automatic frame(output int lat);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, int'(out_valid), 1);
  endtask

  function automatic int sl();
    return int'($signed(left_out));
  endfunction

  function automatic int sr();
    return int'($signed(right_out));
  endfunction

  initial begin
    int lat;
    int ov_before;

    init_vec(0, "single", 375, 375);
    set_ch(0, 0, 100, 15, 3);
    init_vec(1, "sat_pos", 2047, 0);
    for (int c = 0; c < CH; c++) set_ch(1, c, 127, 15, 1);
    init_vec(2, "sat_neg", -2048, 0);
    for (int c = 0; c < CH; c++) set_ch(2, c, -128, 15, 1);
    init_vec(3, "mixed", 64, -64);
    set_ch(3, 0, 64, 8, 1);
    set_ch(3, 1, -64, 4, 3);
    init_vec(4, "vol_zero", 0, 0);
    for (int c = 0; c < CH; c++) set_ch(4, c, 127, 0, 3);
    init_vec(5, "neg_shift", -1, -1);
    set_ch(5, 0, -1, 1, 3);
    init_vec(6, "last_ch_right", 0, 476);
    set_ch(6, 11, 127, 15, 2);

    reset = 1'b1; sample_tick = 1'b0; mute = 1'b0; overrun_clr = 1'b0;
    apply(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_left", sl(), 0);
    chk("rst_right", sr(), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      apply(i);
      frame(lat);
      chk({vecs[i].name, "_latency"}, lat, 13);
      chk({vecs[i].name, "_left"}, sl(), vecs[i].exp_l);
      chk({vecs[i].name, "_right"}, sr(), vecs[i].exp_r);
      @(posedge clk); #1;
      chk({vecs[i].name, "_valid_pulse"}, int'(out_valid), 0);
      chk({vecs[i].name, "_idle"}, int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      chk({vecs[i].name, "_hold_left"}, sl(), vecs[i].exp_l);
    end
    chk("no_overrun_yet", int'(overrun), 0);

    // Second tick five clocks into a frame.
    apply(0);
    ov_before = ov_cnt;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    wait_valid("ovr_frame_valid");
    chk("ovr_left", sl(), 375);
    chk("ovr_right", sr(), 375);
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_one_valid", ov_cnt - ov_before, 1);

    // Clear coinciding with an ignored tick: set wins.
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample_tick = 1'b1; overrun_clr = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0; overrun_clr = 1'b0;
    chk("ovr_clr_vs_set", int'(overrun), 1);
    wait_valid("ovr_clr_frame_valid");
    @(posedge clk); #1;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chk("ovr_clr_alone", int'(overrun), 0);

    // Tick landing on the out_valid cycle is ignored.
    frame(lat);
    chk("coinc_latency", lat, 13);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    chk("coinc_overrun", int'(overrun), 1);
    chk("coinc_not_started", int'(busy), 0);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;

    // Reset partway through the scan abandons the frame.
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    ov_before = ov_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_left", sl(), 0);
    chk("midrst_right", sr(), 0);
    chk("midrst_valid", int'(out_valid), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_valid", ov_cnt - ov_before, 0);
    apply(3);
    frame(lat);
    chk("postrst_latency", lat, 13);
    chk("postrst_left", sl(), 64);
    chk("postrst_right", sr(), -64);
    @(posedge clk); #1;

    // Mute forces zero despite non-zero sums.
    apply(0);
    mute = 1'b1;
    frame(lat);
    chk("mute_latency", lat, 13);
    chk("mute_left", sl(), 0);
    chk("mute_right", sr(), 0);
    mute = 1'b0;
    @(posedge clk); #1;
    frame(lat);
    chk("unmute_left", sl(), 375);
    chk("unmute_right", sr(), 375);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
